wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/processorci_bus_pkg.sv | 20 ++
 rtl/wb_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/processorci_bus_pkg.sv
// Shared bus definitions for the processor's Wishbone interconnect: arbiter
// state encoding, default widths and counter sizing.
package processorci_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // A disabled timeout (0) still needs a legal one-bit counter.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter.sv
// Two-master (instruction/data) Wishbone arbiter onto one memory slave:
// round-robin on ties, single-beat transfers, per-grant ack timeout.
module wb_mem_arbiter
  import processorci_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,

  output logic [1:0]            grant_o
);

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

  arb_state_t       r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  logic w_req0, w_req1;
  logic w_gnt0, w_gnt1;
  logic w_sel_cyc;
  logic w_cnt_hit;
  logic w_timeout;
  logic w_done;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_sel_cyc = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_cnt_hit = 1'b0;
    end
  endgenerate

  // Ack beats a coincident timeout; either one ends the current grant.
  assign w_timeout = w_sel_cyc & ~s_ack_i & w_cnt_hit;
  assign w_done    = w_sel_cyc & (s_ack_i | w_cnt_hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_req0 && (!w_req1 || r_last_grant)) begin
            r_state <= GNT0;
          end else if (w_req1) begin
            r_state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (!w_sel_cyc) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_done) begin
            r_last_grant <= w_gnt1;
            r_cnt        <= '0;
            if (w_gnt0 && w_req1) begin
              r_state <= GNT1;
            end else if (w_gnt1 && w_req0) begin
              r_state <= GNT0;
            end else begin
              r_state <= IDLE;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output is given a default first so no path infers a latch.
  always_comb begin
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (w_gnt0) begin
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (w_gnt1) begin
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign s_cyc_o   = w_sel_cyc;
  assign grant_o   = {w_gnt1, w_gnt0};

  assign m0_ack_o  = s_ack_i & w_gnt0 & m0_cyc_i;
  assign m1_ack_o  = s_ack_i & w_gnt1 & m1_cyc_i;
  assign m0_err_o  = w_timeout & w_gnt0;
  assign m1_err_o  = w_timeout & w_gnt1;

  // Read data is shared, but held at zero while reset is asserted.
  assign m0_data_o = rst ? '0 : s_data_i;
  assign m1_data_o = rst ? '0 : s_data_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_wb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cyc, stb, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic [DW-1:0] s_dat;
  logic          s_ack;

  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [1:0]    grant_o;

  wb_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_dat), .s_ack_i(s_ack),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, who was served last, and how many
  // granted cycles have passed without an ack.
  int owner = -1;
  int last  = 1;
  int waited = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    owner  = -1;
    last   = 1;
    waited = 0;
  endtask

  // Inputs are applied 1 ns after a rising edge; outputs are compared
  // mid-cycle, then the model moves on to the next edge.
  task automatic step(input string tag);
    logic [1:0]  req;
    logic        hit;
    logic [1:0]  exp_gnt;
    logic [66:0] exp_bus;
    logic [3:0]  exp_ae;
    int          k;
    #4;
    req     = cyc & stb;
    k       = owner;
    hit     = (k >= 0) && cyc[k] && !s_ack && (waited == TO - 1);
    exp_gnt = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : 2'b00;
    exp_bus = (k >= 0) ? {cyc[k], stb[k], we[k], addr[k], wdat[k]} : '0;
    exp_ae  = {k == 1 && s_ack && cyc[1], k == 0 && s_ack && cyc[0],
               k == 1 && hit, k == 0 && hit};
    check({tag, "/grant"}, 128'(grant_o), 128'(exp_gnt));
    check({tag, "/slave_bus"},
          128'({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o}), 128'(exp_bus));
    check({tag, "/ack_err"},
          128'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 128'(exp_ae));
    check({tag, "/rdata"}, 128'({m1_data_o, m0_data_o}), 128'({s_dat, s_dat}));

    if (k < 0) begin
      waited = 0;
      if (req == 2'b11) owner = 1 - last;
      else if (req[0])  owner = 0;
      else if (req[1])  owner = 1;
    end else if (!cyc[k]) begin
      owner  = -1;
      waited = 0;
    end else if (s_ack || waited == TO - 1) begin
      last   = k;
      owner  = req[1 - k] ? 1 - k : -1;
      waited = 0;
    end else begin
      waited++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cyc = '0; stb = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdat[0] = '0; wdat[1] = '0;
    s_ack = 1'b0; s_dat = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ctl"},
          128'({grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), '0);
    check({tag, "/bus"}, 128'({s_addr_o, s_data_o, m1_data_o, m0_data_o}), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_master(input int k, input logic c, input logic [AW-1:0] a);
    cyc[k] = c; stb[k] = c; we[k] = 1'b0; addr[k] = a; wdat[k] = 32'h1234_0000 + a;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cyc = 2'b11; stb = 2'b11; s_ack = 1'b1; s_dat = 32'hA5A5_A5A5;
    #2;
    check_all_zero("por");
    idle_inputs();
    do_reset();

    // Single m0 read acked two cycles after s_cyc_o rises.
    set_master(0, 1'b1, 32'h100);
    step("m0_only_req");
    step("m0_only_wait1");
    step("m0_only_wait2");
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    step("m0_only_ack");
    set_master(0, 1'b0, 32'h0); s_ack = 1'b0;
    step("m0_only_idle");

    // Tie from reset: m0 first, then m1 with no bubble.
    do_reset();
    set_master(0, 1'b1, 32'h100);
    set_master(1, 1'b1, 32'h2000);
    step("tie_req");
    s_ack = 1'b1; s_dat = 32'h0000_0100;
    step("tie_ack0");
    set_master(0, 1'b0, 32'h0); s_ack = 1'b0;
    step("tie_gnt1");
    s_ack = 1'b1; s_dat = 32'h0000_2000;
    step("tie_ack1");
    idle_inputs();
    step("tie_idle");

    // Both held high: alternating grants over four transfers.
    set_master(0, 1'b1, 32'h40);
    set_master(1, 1'b1, 32'h80);
    for (int i = 0; i < 9; i++) begin
      s_ack = i[0];
      s_dat = 32'hC0DE_0000 + i;
      step("rr_held");
    end
    idle_inputs();
    step("rr_idle");

    // m1 granted, slave never acks: error in the 8th granted cycle.
    set_master(1, 1'b1, 32'h3000);
    for (int i = 0; i < TO + 3; i++) step("timeout");
    idle_inputs();
    step("timeout_idle");
    step("timeout_idle2");

    // Reset asserted mid-grant of m1, then tie resolves to m0.
    set_master(0, 1'b1, 32'h500);
    set_master(1, 1'b1, 32'h600);
    step("mid_rst_req");
    s_ack = 1'b1; s_dat = 32'h5555_0000;
    step("mid_rst_ack0");
    s_ack = 1'b0;
    step("mid_rst_gnt1");
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_hold");
    rst = 1'b0;
    model_reset();
    step("post_rst_req");
    step("post_rst_gnt0");

    // Randomized traffic: normal ack rate, then a starved slave.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        for (int k = 0; k < 2; k++) begin
          if ($urandom_range(0, 5) == 0) cyc[k] = ~cyc[k];
          stb[k]  = cyc[k] & ($urandom_range(0, 7) != 0);
          we[k]   = 1'($urandom);
          addr[k] = $urandom;
          wdat[k] = $urandom;
        end
        s_ack = ($urandom_range(0, 99) < ((ph == 0) ? 40 : 6));
        s_dat = $urandom;
        step(ph == 0 ? "rand" : "rand_slow");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
